// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: IDLE/RUN/PAUSE sequencer for the 4-LED chaser.
// Drives a one-hot LED vector, the 2-bit LED index, a running flag and a
// one-cycle tick on every automatic advance. Dwell is BASE_DIV >> speed_sel.
// Optional build macro: LED_SEQ_BOUNCE_EN selects ping-pong sequencing
// (0-1-2-3-2-1-0-...) using an internal direction register loaded on start.
module led_seq_ctrl #(
    parameter int BASE_DIV = 12_500_000,
    parameter int DIV_W    = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       dir,
    input  logic [1:0] speed_sel,
    output logic [3:0] led,
    output logic [1:0] led_idx,
    output logic       running,
    output logic       tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] BASE_DIV_C = DIV_W'(BASE_DIV);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_led;
    logic             r_running;
    logic             r_tick;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [1:0]       w_idx_nxt;
    logic [3:0]       w_led_nxt;
    logic             w_running_nxt;
    logic             w_tick_nxt;

    logic [DIV_W-1:0] w_dwell;
    logic [DIV_W-1:0] w_dwell_m1;
    logic             w_dwell_done;
    logic             w_adv_dir;
    logic [1:0]       w_adv_idx;

`ifdef LED_SEQ_BOUNCE_EN
    logic             r_dir;
    logic             w_dir_nxt;
    logic             w_adv_flip;
`endif

    // Dwell length and advance target, recomputed every cycle
    always_comb begin
        w_dwell      = BASE_DIV_C >> speed_sel;
        w_dwell_m1   = w_dwell - 1'b1;
        // >= rather than == so a shortened dwell can never be overrun
        w_dwell_done = (r_cnt >= w_dwell_m1);
`ifdef LED_SEQ_BOUNCE_EN
        w_adv_dir    = r_dir;
`else
        w_adv_dir    = dir;
`endif
        w_adv_idx    = w_adv_dir ? (r_idx - 2'd1) : (r_idx + 2'd1);
`ifdef LED_SEQ_BOUNCE_EN
        w_adv_flip   = (!w_adv_dir && (w_adv_idx == 2'd3)) ||
                       ( w_adv_dir && (w_adv_idx == 2'd0));
`endif
    end

    // Next-state and next-output logic; stop > start > step
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_tick_nxt  = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
        w_dir_nxt   = r_dir;
`endif
        unique case (r_state)
            ST_IDLE: begin
                // a coincident stop outranks start, and stop is a no-op here
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
`ifdef LED_SEQ_BOUNCE_EN
                    w_dir_nxt   = dir;
`endif
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_dwell_done) begin
                    w_cnt_nxt  = '0;
                    w_tick_nxt = 1'b1;
                    w_idx_nxt  = w_adv_idx;
`ifdef LED_SEQ_BOUNCE_EN
                    if (w_adv_flip) w_dir_nxt = ~r_dir;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else if (step) begin
                    w_idx_nxt = w_adv_idx;
`ifdef LED_SEQ_BOUNCE_EN
                    if (w_adv_flip) w_dir_nxt = ~r_dir;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 2'd0;
            end
        endcase

        // outputs are decoded from the next state so they register together
        w_led_nxt     = (w_state_nxt == ST_IDLE) ? 4'b0000 : (4'b0001 << w_idx_nxt);
        w_running_nxt = (w_state_nxt == ST_RUN);
    end

    // State and output registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_led     <= 4'b0000;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_led     <= w_led_nxt;
            r_running <= w_running_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

`ifdef LED_SEQ_BOUNCE_EN
    // Ping-pong direction register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_dir <= 1'b0;
        else      r_dir <= w_dir_nxt;
    end
`endif

    assign led     = r_led;
    assign led_idx = r_idx;
    assign running = r_running;
    assign tick    = r_tick;

endmodule
